sample_read_arbiter: RTL and testbench

- Shares the single read port of the sample BRAM among NUM_REQ requesters: oscillators, the visualiser and the UART debugger.
- Round-robin, one grant per cycle, with a fixed-latency read pipeline that returns data tagged to the granted requester.
- Sits between the oscillators/viz/debug index sources and the BRAM read port inside the memory subsystem.
- Blocks new grants while the loader rewrites the BRAM after a UI update, then resumes.

---
 rtl/sample_read_arbiter.sv | 134 +++++++++++++
 tb/tb_sample_read_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_read_arbiter.sv
// rtl/sample_read_arbiter.sv - round-robin arbiter for the sample BRAM read port with tagged fixed-latency returns
// Optional: define SAMPLE_READ_ARB_PRIO0_EN to give requester 0 absolute priority.
module sample_read_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 18,
  parameter int SAMPLE_WIDTH = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_REQ-1:0]            req_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_in,
  output logic [NUM_REQ-1:0]            gnt_out,
  output logic [NUM_REQ-1:0]            rvalid_out,
  output logic [SAMPLE_WIDTH-1:0]       rdata_out,
  input  logic                          mem_busy_in,
  output logic                          drained_out,
  output logic [ADDR_WIDTH-1:0]         bram_addr_out,
  output logic                          bram_en_out,
  input  logic [SAMPLE_WIDTH-1:0]       bram_data_in
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {ARB, DRAIN, BLOCKED} state_t;

  state_t                  state, state_nxt;
  logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic                    rr_hit, prio_hit, grant_nxt, in_flight;
  logic [PTR_W-1:0]        rr_win, win_idx, gnt_idx;
  logic [PTR_W:0]          scan_sum;
  logic [NUM_REQ-1:0]      gnt_nxt;
  logic [READ_LATENCY-1:0] tag_vld;
  logic [PTR_W-1:0]        tag_idx [READ_LATENCY];
  logic [SAMPLE_WIDTH-1:0] rdata_q;

  // Reverse scan so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    rr_hit   = 1'b0;
    rr_win   = '0;
    scan_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      if (req_in[scan_sum[PTR_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_win = scan_sum[PTR_W-1:0];
      end
    end
  end

`ifdef SAMPLE_READ_ARB_PRIO0_EN
  assign prio_hit = req_in[0];
`else
  assign prio_hit = 1'b0;
`endif

  // A read is in flight from the cycle bram_en_out is high until its rvalid cycle.
  assign in_flight = bram_en_out | (|tag_vld);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= ARB;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = 1'b0;
    win_idx    = rr_win;
    gnt_nxt    = '0;
    case (state)
      ARB: begin
        if (mem_busy_in) begin
          state_nxt = DRAIN;
        end else if (prio_hit) begin
          grant_nxt = 1'b1;
          win_idx   = '0;
        end else if (rr_hit) begin
          grant_nxt  = 1'b1;
          win_idx    = rr_win;
          rr_ptr_nxt = (rr_win == PTR_W'(NUM_REQ - 1)) ? '0 : rr_win + PTR_W'(1);
        end
      end
      DRAIN: begin
        if (!mem_busy_in)    state_nxt = ARB;
        else if (!in_flight) state_nxt = BLOCKED;
      end
      BLOCKED: begin
        if (!mem_busy_in) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
    if (grant_nxt) gnt_nxt[win_idx] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr        <= '0;
      gnt_out       <= '0;
      gnt_idx       <= '0;
      bram_en_out   <= 1'b0;
      bram_addr_out <= '0;
      tag_vld       <= '0;
      rdata_q       <= '0;
      for (int k = 0; k < READ_LATENCY; k++) tag_idx[k] <= '0;
    end else begin
      rr_ptr      <= rr_ptr_nxt;
      gnt_out     <= gnt_nxt;
      bram_en_out <= grant_nxt;
      if (grant_nxt) begin
        gnt_idx       <= win_idx;
        bram_addr_out <= addr_in[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
      end
      // Tag stage 0 follows the issued read, so the last stage lines up with BRAM data.
      tag_vld[0] <= bram_en_out;
      tag_idx[0] <= gnt_idx;
      for (int k = 1; k < READ_LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
      if (tag_vld[READ_LATENCY-1]) rdata_q <= bram_data_in;
    end
  end

  always_comb begin
    rvalid_out = '0;
    if (tag_vld[READ_LATENCY-1]) rvalid_out[tag_idx[READ_LATENCY-1]] = 1'b1;
  end

  assign rdata_out   = tag_vld[READ_LATENCY-1] ? bram_data_in : rdata_q;
  assign drained_out = (state == BLOCKED);

endmodule

// File: tb/tb_sample_read_arbiter.sv
// tb/tb_sample_read_arbiter.sv - directed and random checks of sample_read_arbiter against a queue-based model
module tb_sample_read_arbiter;

  localparam int N  = 4;
  localparam int AW = 18;
  localparam int SW = 16;
  localparam int RL = 2;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b1;
  logic [N-1:0]    req_in = '0;
  logic [N*AW-1:0] addr_in = '0;
  logic            mem_busy_in = 1'b0;
  logic [SW-1:0]   bram_data_in;
  logic [N-1:0]    gnt_out, rvalid_out;
  logic [SW-1:0]   rdata_out;
  logic            drained_out, bram_en_out;
  logic [AW-1:0]   bram_addr_out;

  always #5 clk_in = ~clk_in;

  sample_read_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .READ_LATENCY(RL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .addr_in(addr_in),
    .gnt_out(gnt_out), .rvalid_out(rvalid_out), .rdata_out(rdata_out),
    .mem_busy_in(mem_busy_in), .drained_out(drained_out),
    .bram_addr_out(bram_addr_out), .bram_en_out(bram_en_out), .bram_data_in(bram_data_in)
  );

  function automatic logic [SW-1:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] p;
    p = 32'(a) * 32'd40503 + 32'h3c5a;
    return p[SW-1:0] ^ SW'(a >> 7);
  endfunction

  // BRAM: data for an address appears RL cycles after it is presented
  logic [AW-1:0] bp [RL];
  always @(posedge clk_in) begin
    bp[0] <= bram_addr_out;
    for (int k = 1; k < RL; k++) bp[k] <= bp[k-1];
  end
  assign bram_data_in = mem_word(bp[RL-1]);

  typedef struct { int due; int idx; logic [AW-1:0] a; } rd_t;
  rd_t           rq[$];
  int            cyc = 0, checks = 0, errors = 0;
  int            m_mode, m_rr, last_due;
  logic [N-1:0]  e_gnt;
  logic          e_en;
  logic [AW-1:0] e_addr;
  logic [SW-1:0] e_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic reset_model();
    m_mode = 0; m_rr = 0; last_due = -1;
    e_gnt = '0; e_en = 1'b0; e_addr = '0; e_rdata = '0;
    rq.delete();
  endtask

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int j;
`ifdef SAMPLE_READ_ARB_PRIO0_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      j = (ptr + k) % N;
      if (((r >> j) & N'(1)) != '0) return j;
    end
    return -1;
  endfunction

  // Predicts the effect of the coming clock edge from the inputs now applied.
  task automatic predict();
    int w;
    if (!rst_in) begin
      reset_model();
      return;
    end
    e_gnt = '0;
    e_en  = 1'b0;
    case (m_mode)
      0: if (mem_busy_in) m_mode = 1;
         else begin
           w = pick(req_in, m_rr);
           if (w >= 0) begin
             e_gnt  = N'(1) << w;
             e_en   = 1'b1;
             e_addr = addr_in[w*AW +: AW];
             last_due = cyc + 1 + RL;
             rq.push_back('{last_due, w, e_addr});
`ifdef SAMPLE_READ_ARB_PRIO0_EN
             if (w != 0) m_rr = (w + 1) % N;
`else
             m_rr = (w + 1) % N;
`endif
           end
         end
      1: if (!mem_busy_in) m_mode = 0;
         else if (last_due < cyc) m_mode = 2;
      default: if (!mem_busy_in) m_mode = 0;
    endcase
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_rv;
    e_rv = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_rv    = N'(1) << rq[0].idx;
      e_rdata = mem_word(rq[0].a);
      void'(rq.pop_front());
    end
    chk("gnt_out",       32'(gnt_out),       32'(e_gnt));
    chk("bram_en_out",   32'(bram_en_out),   32'(e_en));
    chk("bram_addr_out", 32'(bram_addr_out), 32'(e_addr));
    chk("rvalid_out",    32'(rvalid_out),    32'(e_rv));
    chk("rdata_out",     32'(rdata_out),     32'(e_rdata));
    chk("drained_out",   32'(drained_out),   32'(m_mode == 2));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      predict();
      @(posedge clk_in);
      cyc++;
      @(negedge clk_in);
      check_outputs();
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr_in[i*AW +: AW] = a;
  endtask

  initial begin
    reset_model();
    #2 rst_in = 1'b0;
    step(2);
    rst_in = 1'b1;

    // reset while a read to requester 2 is in flight
    set_addr(2, 18'h00100);
    req_in = 4'b0100;
    step(1);
    rst_in = 1'b0;
    reset_model();
    #1 check_outputs();
    req_in = 4'b1111;
    step(3);
    rst_in = 1'b1;

    // everyone requesting continuously
    set_addr(0, 18'h10); set_addr(1, 18'h20); set_addr(2, 18'h30); set_addr(3, 18'h40);
    step(12);
    req_in = '0;
    step(RL + 1);

    // lone requester gets every cycle
    set_addr(3, 18'h2abcd);
    req_in = 4'b1000;
    step(5);
    req_in = '0;
    step(RL + 1);

    // busy with reads in flight, then resume
    req_in = 4'b1111;
    step(2);
    mem_busy_in = 1'b1;
    step(6);
    mem_busy_in = 1'b0;
    step(6);
    req_in = '0;
    step(RL + 1);

    // busy and a request arriving together
    mem_busy_in = 1'b1;
    req_in = 4'b0010;
    step(4);
    mem_busy_in = 1'b0;
    step(2);
    req_in = '0;
    step(RL + 1);

    // busy drops while still draining
    req_in = 4'b1111;
    step(2);
    mem_busy_in = 1'b1;
    step(1);
    mem_busy_in = 1'b0;
    step(4);
    req_in = '0;
    step(RL + 1);

`ifdef SAMPLE_READ_ARB_PRIO0_EN
    req_in = 4'b0011;
    step(6);
    req_in = 4'b0010;
    step(3);
    req_in = '0;
    step(RL + 1);
`endif

    // random requesters that drop on grant, with random busy windows
    for (int c = 0; c < 400; c++) begin
      step(1);
      req_in = req_in & ~e_gnt;
      for (int i = 0; i < N; i++) begin
        if ((((req_in >> i) & N'(1)) == '0) && $urandom_range(0, 2) == 0) begin
          req_in = req_in | (N'(1) << i);
          set_addr(i, AW'($urandom));
        end
      end
      if (mem_busy_in) begin
        if ($urandom_range(0, 5) == 0) mem_busy_in = 1'b0;
      end else if ($urandom_range(0, 24) == 0) begin
        mem_busy_in = 1'b1;
      end
    end
    req_in = '0;
    mem_busy_in = 1'b0;
    step(RL + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
